// File: rtl/secventiator_faze.sv
// Traffic-light phase sequencer: latches requests, serves them round-robin with
// all-red clearance, waits for the light module's ready and times the green.
module secventiator_faze #(
  parameter int T_ROSU_TOT  = 2,
  parameter int T_VERDE_MIN = 5,
  parameter int T_VERDE_MAX = 15,
  parameter int T_TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_div_int,
  input  logic       cerere_S,
  input  logic       cerere_E,
  input  logic       cerere_V,
  input  logic       cerere_N,
  input  logic       cerere_P,
  input  logic       ready_S,
  input  logic       ready_E,
  input  logic       ready_V,
  input  logic       ready_N,
  input  logic       ready_P,
  output logic [2:0] stare_semafor,
  output logic       faza_activa,
  output logic [4:0] cereri_pend,
  output logic       defect
);

  localparam int MAX_AB  = (T_ROSU_TOT > T_VERDE_MIN) ? T_ROSU_TOT : T_VERDE_MIN;
  localparam int MAX_CD  = (T_VERDE_MAX > T_TIMEOUT) ? T_VERDE_MAX : T_TIMEOUT;
  localparam int MAX_T   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] C_ROSU    = CW'(T_ROSU_TOT);
  localparam logic [CW-1:0] C_VMIN    = CW'(T_VERDE_MIN);
  localparam logic [CW-1:0] C_VMAX    = CW'(T_VERDE_MAX);
  localparam logic [CW-1:0] C_TIMEOUT = CW'(T_TIMEOUT);

  localparam logic [2:0] STARE_ALL_ROSU = 3'd0;
  localparam logic [2:0] STARE_DEFECT   = 3'd6;
  localparam logic [2:0] IDX_P          = 3'd4;

  typedef enum logic [2:0] {
    ROSU_TOT, ARBITRARE, ASTEPT_READY, VERDE, DEFECT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    pend_q, pend_d;
  logic [2:0]    ultim_q, ultim_d;   // last selected phase index, S=0 .. P=4
  logic [2:0]    stare_q, stare_d;
  logic          faza_q, faza_d;
  logic          defect_q, defect_d;

  logic [4:0]    req_vec, rdy_vec, served_mask, others;
  logic [9:0]    rot;
  logic          sel_valid;
  logic [2:0]    sel_off, sel_idx;
  logic [3:0]    sel_sum;
  logic [CW-1:0] cnt_inc, green_nxt;

  assign req_vec = {cerere_P, cerere_N, cerere_V, cerere_E, cerere_S};
  assign rdy_vec = {ready_P, ready_N, ready_V, ready_E, ready_S};
  assign cnt_inc = cnt_q + 1'b1;

  // Round-robin: rotate the doubled request vector so the phase after
  // ultim_servit lands at bit 0, then take the lowest set bit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_valid = 1'b0;
    sel_off   = 3'd0;
    rot       = {pend_q, pend_q} >> (ultim_q + 3'd1);
    for (int j = 4; j >= 0; j--) begin
      if (rot[j]) begin
        sel_valid = 1'b1;
        sel_off   = 3'(j);
      end
    end
    sel_sum = 4'(ultim_q) + 4'd1 + 4'(sel_off);
    sel_idx = (sel_sum >= 4'd5) ? 3'(sel_sum - 4'd5) : 3'(sel_sum);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ultim_d     = ultim_q;
    served_mask = 5'b00001 << ultim_q;
    others      = pend_q & ~served_mask;
    green_nxt   = (cnt_q >= C_VMAX) ? C_VMAX : cnt_inc;

    unique case (state_q)
      ROSU_TOT: if (clk_div_int) begin
        if (cnt_inc >= C_ROSU) begin
          state_d = ARBITRARE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ARBITRARE: if (sel_valid) begin
        state_d = ASTEPT_READY;
        ultim_d = sel_idx;
        cnt_d   = '0;
      end
      ASTEPT_READY: begin
        if (rdy_vec[ultim_q]) begin
          state_d = VERDE;
          cnt_d   = '0;
        end else if (clk_div_int) begin
          if (cnt_inc >= C_TIMEOUT) begin
            state_d = DEFECT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      VERDE: if (clk_div_int) begin
        cnt_d = green_nxt;
        if ((green_nxt >= C_VMIN && |others) || green_nxt == C_VMAX) begin
          state_d = ROSU_TOT;
          cnt_d   = '0;
        end
      end
      DEFECT: ;
      default: begin
        state_d = ROSU_TOT;
        cnt_d   = '0;
      end
    endcase

    // The served phase's request is suppressed for the whole green, including
    // a request arriving on the very cycle green is entered.
    pend_d = pend_q | req_vec;
    if (state_d == VERDE) pend_d = pend_d & ~(5'b00001 << ultim_d);

    unique case (state_d)
      ASTEPT_READY, VERDE: stare_d = ultim_d + 3'd1;
      DEFECT:              stare_d = STARE_DEFECT;
      default:             stare_d = STARE_ALL_ROSU;
    endcase
    faza_d   = (state_d == VERDE);
    defect_d = (state_d == DEFECT);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q  <= ROSU_TOT;
      cnt_q    <= '0;
      pend_q   <= '0;
      ultim_q  <= IDX_P;
      stare_q  <= STARE_ALL_ROSU;
      faza_q   <= 1'b0;
      defect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ultim_q  <= ultim_d;
      stare_q  <= stare_d;
      faza_q   <= faza_d;
      defect_q <= defect_d;
    end
  end

  assign stare_semafor = stare_q;
  assign faza_activa   = faza_q;
  assign cereri_pend   = pend_q;
  assign defect        = defect_q;

endmodule

// File: doc/secventiator_faze.md
SECVENTIATOR_FAZE -- requirements
Module: secventiator_faze

Interface
REQ-001 Parameters (name, default, meaning) SHALL be one per line:
- T_ROSU_TOT, 2: all-red clearance length, in ticks.
- T_VERDE_MIN, 5: minimum green length, in ticks.
- T_VERDE_MAX, 15: maximum green length, in ticks.
- T_TIMEOUT, 8: maximum wait for ready, in ticks.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- clk_div_int, in, 1: one-clk-wide tick enable, all timing counts these.
- cerere_S, cerere_E, cerere_V, cerere_N, cerere_P, in, 1 each: vehicle sensor / pedestrian button, level.
- ready_S, ready_E, ready_V, ready_N, ready_P, in, 1 each: light module reached green for the commanded phase.
- stare_semafor, out, 3: commanded phase, registered.
- faza_activa, out, 1: 1 while the green timer runs.
- cereri_pend, out, 5: latched requests, bit order {P,N,V,E,S}.
- defect, out, 1: sticky fault flag.
REQ-003 The block SHALL have one clock and use a synchronous, active-high reset, named clk and rst.

Function
REQ-004 stare_semafor encoding SHALL be: 0 ALL_ROSU, 1 SUD, 2 EST, 3 VEST, 4 NORD, 5 PIETONI, 6 DEFECT; 7 is never driven.
REQ-005 FSM states SHALL be ROSU_TOT, ARBITRARE, ASTEPT_READY, VERDE and DEFECT.
REQ-006 Each cycle, cereri_pend[i] SHALL be set if cerere_i=1.
REQ-007 The bit of the served phase SHALL be held 0 while the FSM is in VERDE for that phase, and a same-cycle set SHALL be dropped.
REQ-008 ROSU_TOT: stare_semafor=0; after T_ROSU_TOT ticks the FSM SHALL go to ARBITRARE.
REQ-009 ARBITRARE SHALL take exactly 1 cycle.
REQ-010 ARBITRARE SHALL select, round-robin, the first pending bit strictly after ultim_servit, in order S,E,V,N,P and wrapping P->S.
REQ-011 ARBITRARE with no pending bit SHALL return to ARBITRARE and hold stare_semafor=0 until a request arrives.
REQ-012 On a selection, the next cycle SHALL register stare_semafor=phase and update ultim_servit, with the FSM in ASTEPT_READY.
REQ-013 ASTEPT_READY: when the selected ready is 1, the next cycle SHALL be VERDE with faza_activa=1 and the green counter at 0.
REQ-014 Ready inputs of non-selected phases SHALL be ignored.
REQ-015 ASTEPT_READY: if T_TIMEOUT ticks elapse without ready, the FSM SHALL enter DEFECT.
REQ-016 VERDE: the green counter SHALL increment on each tick and saturate at T_VERDE_MAX.
REQ-017 VERDE SHALL exit to ROSU_TOT, with faza_activa=0 and stare_semafor=0 registered the next cycle, when (counter>=T_VERDE_MIN and some other pending bit is 1) or counter==T_VERDE_MAX.
REQ-018 VERDE with no other request SHALL extend only up to T_VERDE_MAX.
REQ-019 DEFECT: stare_semafor=6 and defect=1; the state SHALL only be exited by rst, and requests SHALL keep latching.
REQ-020 Timing counters SHALL change only on cycles with clk_div_int=1, and state transitions SHALL occur on the clk edge after the qualifying tick.
REQ-021 A request and a tick in the same cycle SHALL both take effect.
REQ-022 Counters SHALL be wide enough for the largest parameter, and SHALL never wrap.

Reset
REQ-023 With rst=1 at a clk edge, the next-cycle values SHALL be: state ROSU_TOT, stare_semafor=0, faza_activa=0, cereri_pend=0, defect=0, ultim_servit=P (so S has first priority), all counters 0.
REQ-024 rst SHALL take priority over every other input, including mid-VERDE and in DEFECT.

Verification
REQ-025 Reset, cerere_E pulse for 1 cycle, ready_E returned 3 cycles after command -> stare_semafor 0->2, cereri_pend[1] clears on VERDE, green lasts exactly T_VERDE_MAX=15 ticks, then 0 for 2 ticks.
REQ-026 cerere_S and cerere_N held high from reset, ready returned immediately -> phases 1, 0, 4, 0, 1 ... alternating, each green exactly T_VERDE_MIN=5 ticks.
REQ-027 All five requests held, immediate ready -> service order 1, 2, 3, 4, 5, then 1; no phase is skipped.
REQ-028 cerere_P, ready_P never asserted -> stare_semafor=5 for 8 ticks, then 6 with defect=1; it stays 6 with requests applied; rst returns to 0.
REQ-029 rst asserted in VERDE of phase 3 at tick 4 -> next cycle: stare_semafor=0, faza_activa=0, cereri_pend=0; the next arbitration serves S first.
REQ-030 clk_div_int held 0 -> no state ever advances beyond ARBITRARE/ASTEPT_READY, and the counters stay frozen.
